// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access pipeline stage: access-size
// encodings, data-memory geometry and the byte-lane mask helper.
package mem_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned MEM_DEPTH  = 1024;
  localparam int unsigned MEM_ADDR_W = 10;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned BE_W       = DATA_W / 8;

  typedef enum logic [1:0] {
    MEM_WORD = 2'b00,
    MEM_HALF = 2'b01,
    MEM_BYTE = 2'b10,
    MEM_RSVD = 2'b11
  } mem_size_e;

  // Little-endian byte-enable mask for an access of the given size at lane offset lo.
  function automatic logic [BE_W-1:0] lane_mask(input mem_size_e size, input logic [1:0] lo);
    logic [BE_W-1:0] mask;
    case (size)
      MEM_BYTE: mask = BE_W'(4'b0001 << lo);
      MEM_HALF: mask = lo[1] ? 4'b1100 : 4'b0011;
      default:  mask = 4'b1111;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Request/result bundle between the execute stage (master) and the
// memory-access stage (slave).
interface mem_access_stage_if;
  import mem_pkg::*;

  logic [DATA_W-1:0]     address;
  logic [DATA_W-1:0]     write_data;
  logic                  mem_read;
  logic                  mem_write;
  mem_size_e             mem_size;
  logic                  load_unsigned;
  logic                  reg_write_in;
  logic                  mem_to_reg_in;
  logic [REG_ADDR_W-1:0] reg_dest_address_in;
  logic                  stall;
  logic                  flush;

  logic [DATA_W-1:0]     read_data_out;
  logic [DATA_W-1:0]     alu_result_out;
  logic                  reg_write_out;
  logic                  mem_to_reg_out;
  logic [REG_ADDR_W-1:0] reg_dest_address_out;
  logic                  misalign_err;

  modport master (
    output address, write_data, mem_read, mem_write, mem_size, load_unsigned,
           reg_write_in, mem_to_reg_in, reg_dest_address_in, stall, flush,
    input  read_data_out, alu_result_out, reg_write_out, mem_to_reg_out,
           reg_dest_address_out, misalign_err
  );

  modport slave (
    input  address, write_data, mem_read, mem_write, mem_size, load_unsigned,
           reg_write_in, mem_to_reg_in, reg_dest_address_in, stall, flush,
    output read_data_out, alu_result_out, reg_write_out, mem_to_reg_out,
           reg_dest_address_out, misalign_err
  );

endinterface

// File: rtl/mem_access_stage_data_mem_array.sv
// 1024 x 32-bit data memory with per-byte write enables and an
// asynchronous read port; contents are intentionally not reset.
module data_mem_array
  import mem_pkg::*;
(
  input  logic                  clk,
  input  logic [BE_W-1:0]       be,
  input  logic [MEM_ADDR_W-1:0] index,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata_c
);

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  assign rdata_c = mem[index];

  always_ff @(posedge clk) begin
    for (int l = 0; l < int'(BE_W); l++) begin
      if (be[l]) mem[index][l*8 +: 8] <= wdata[l*8 +: 8];
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// Pipeline memory-access stage: lane steering, load extension and the stage register.
// Optional MISALIGN_TRAP_EN traps misaligned half/word accesses instead of aligning them down.
module mem_access_stage
  import mem_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  mem_access_stage_if.slave bus
);

  mem_size_e             size;
  logic                  is_half;
  logic                  is_byte;
  logic                  trap_c;
  logic [1:0]            lane_lo;
  logic [MEM_ADDR_W-1:0] index;
  logic                  store_en;
  logic [BE_W-1:0]       be;
  logic [DATA_W-1:0]     wdata_lanes;
  logic [DATA_W-1:0]     rword_c;
  logic [DATA_W-1:0]     shifted;
  logic [DATA_W-1:0]     load_ext;
  logic [DATA_W-1:0]     read_next;

  assign size    = bus.mem_size;
  assign is_half = (size == MEM_HALF);
  assign is_byte = (size == MEM_BYTE);
  assign index   = bus.address[MEM_ADDR_W+1:2];

`ifdef MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = (is_half && bus.address[0]) ||
                      (!is_half && !is_byte && (bus.address[1:0] != 2'b00));
  assign trap_c     = (bus.mem_read || bus.mem_write) && misaligned;
`else
  assign trap_c     = 1'b0;
`endif

  // Lane offset is always aligned down; when trapping, the access is squashed anyway.
  always_comb begin
    lane_lo = 2'b00;
    if (is_byte)      lane_lo = bus.address[1:0];
    else if (is_half) lane_lo = {bus.address[1], 1'b0};
  end

  assign store_en = bus.mem_write && !bus.stall && !bus.flush && !rst && !trap_c;
  assign be       = store_en ? lane_mask(size, lane_lo) : '0;

  always_comb begin
    wdata_lanes = bus.write_data;
    if (is_byte)      wdata_lanes = {4{bus.write_data[7:0]}};
    else if (is_half) wdata_lanes = {2{bus.write_data[15:0]}};
  end

  data_mem_array u_array (
    .clk     (clk),
    .be      (be),
    .index   (index),
    .wdata   (wdata_lanes),
    .rdata_c (rword_c)
  );

  // Read happens before the edge, so a same-cycle store returns the old word.
  assign shifted = rword_c >> {lane_lo, 3'b000};

  always_comb begin
    load_ext = shifted;
    if (is_byte) begin
      load_ext = bus.load_unsigned ? {24'h0, shifted[7:0]}
                                   : {{24{shifted[7]}}, shifted[7:0]};
    end else if (is_half) begin
      load_ext = bus.load_unsigned ? {16'h0, shifted[15:0]}
                                   : {{16{shifted[15]}}, shifted[15:0]};
    end
  end

  assign read_next = (bus.mem_read && !trap_c) ? load_ext : '0;

  // Stage register: flush beats stall; reset is asynchronous.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.read_data_out        <= '0;
      bus.alu_result_out       <= '0;
      bus.reg_write_out        <= 1'b0;
      bus.mem_to_reg_out       <= 1'b0;
      bus.reg_dest_address_out <= '0;
      bus.misalign_err         <= 1'b0;
    end else if (bus.flush) begin
      bus.read_data_out        <= '0;
      bus.alu_result_out       <= '0;
      bus.reg_write_out        <= 1'b0;
      bus.mem_to_reg_out       <= 1'b0;
      bus.reg_dest_address_out <= '0;
      bus.misalign_err         <= 1'b0;
    end else if (!bus.stall) begin
      bus.read_data_out        <= read_next;
      bus.alu_result_out       <= bus.address;
      bus.reg_write_out        <= bus.reg_write_in && !trap_c;
      bus.mem_to_reg_out       <= bus.mem_to_reg_in;
      bus.reg_dest_address_out <= bus.reg_dest_address_in;
      bus.misalign_err         <= trap_c;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage; expectations follow
// MISALIGN_TRAP_EN when the build defines it.
module tb_mem_access_stage;
  import mem_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  mem_access_stage_if bus ();

  mem_access_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request for one clock edge.
  task automatic issue(input logic [31:0] addr, input logic [31:0] wdata,
                       input logic rd, input logic wr, input mem_size_e size,
                       input logic uns, input logic regw, input logic [4:0] rdest);
    bus.address             = addr;
    bus.write_data          = wdata;
    bus.mem_read            = rd;
    bus.mem_write           = wr;
    bus.mem_size            = size;
    bus.load_unsigned       = uns;
    bus.reg_write_in        = regw;
    bus.mem_to_reg_in       = rd;
    bus.reg_dest_address_in = rdest;
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b0;
    bus.address = '0; bus.write_data = '0; bus.mem_read = 1'b0; bus.mem_write = 1'b0;
    bus.mem_size = MEM_WORD; bus.load_unsigned = 1'b0; bus.reg_write_in = 1'b0;
    bus.mem_to_reg_in = 1'b0; bus.reg_dest_address_in = '0; bus.stall = 1'b0; bus.flush = 1'b0;

    // Reset state, with active requests on the bus that must be ignored
    #1 rst = 1'b1;
    bus.address = 32'h10; bus.reg_write_in = 1'b1; bus.reg_dest_address_in = 5'd3;
    tick();
    check("rst_read",  bus.read_data_out, 32'h0);
    check("rst_alu",   bus.alu_result_out, 32'h0);
    check("rst_regw",  32'(bus.reg_write_out), 32'h0);
    check("rst_rdest", 32'(bus.reg_dest_address_out), 32'h0);
    check("rst_mis",   32'(bus.misalign_err), 32'h0);
    rst = 1'b0;

    // Word store then word load
    issue(32'h10, 32'hDEADBEEF, 1'b0, 1'b1, MEM_WORD, 1'b0, 1'b0, 5'd0);
    check("st_alu", bus.alu_result_out, 32'h10);
    check("st_read_zero", bus.read_data_out, 32'h0);
    issue(32'h10, 32'h0, 1'b1, 1'b0, MEM_WORD, 1'b0, 1'b1, 5'd5);
    check("ld_word", bus.read_data_out, 32'hDEADBEEF);
    check("ld_regw", 32'(bus.reg_write_out), 32'h1);
    check("ld_m2r", 32'(bus.mem_to_reg_out), 32'h1);
    check("ld_rdest", 32'(bus.reg_dest_address_out), 32'd5);

    // Byte store into a known word, then sub-word loads
    issue(32'h20, 32'h44332211, 1'b0, 1'b1, MEM_WORD, 1'b0, 1'b0, 5'd0);
    issue(32'h21, 32'hABCDEF80, 1'b0, 1'b1, MEM_BYTE, 1'b0, 1'b0, 5'd0);
    issue(32'h21, 32'h0, 1'b1, 1'b0, MEM_BYTE, 1'b0, 1'b1, 5'd2);
    check("lb_signed", bus.read_data_out, 32'hFFFFFF80);
    issue(32'h21, 32'h0, 1'b1, 1'b0, MEM_BYTE, 1'b1, 1'b1, 5'd2);
    check("lb_unsigned", bus.read_data_out, 32'h00000080);
    issue(32'h20, 32'h0, 1'b1, 1'b0, MEM_WORD, 1'b0, 1'b1, 5'd2);
    check("lw_neighbors", bus.read_data_out, 32'h44338011);
    issue(32'h23, 32'h0, 1'b1, 1'b0, MEM_BYTE, 1'b0, 1'b1, 5'd2);
    check("lb_lane3", bus.read_data_out, 32'h00000044);
    issue(32'h22, 32'h0, 1'b1, 1'b0, MEM_HALF, 1'b0, 1'b1, 5'd2);
    check("lh_upper", bus.read_data_out, 32'h00004433);
    issue(32'h20, 32'h0, 1'b1, 1'b0, MEM_HALF, 1'b0, 1'b1, 5'd2);
    check("lh_signed", bus.read_data_out, 32'hFFFF8011);
    issue(32'h20, 32'h0, 1'b1, 1'b0, MEM_HALF, 1'b1, 1'b1, 5'd2);
    check("lh_unsigned", bus.read_data_out, 32'h00008011);
    issue(32'h1E, 32'hBEEF1234, 1'b0, 1'b1, MEM_HALF, 1'b0, 1'b0, 5'd0);
    issue(32'h1C, 32'h0, 1'b1, 1'b0, MEM_WORD, 1'b0, 1'b1, 5'd2);
    check("sh_upper_lane", bus.read_data_out[31:16], 16'h1234);

    // Stall holds outputs and blocks the store
    issue(32'h40, 32'h55667788, 1'b0, 1'b1, MEM_WORD, 1'b0, 1'b0, 5'd0);
    issue(32'h20, 32'h0, 1'b1, 1'b0, MEM_WORD, 1'b0, 1'b1, 5'd7);
    bus.stall = 1'b1;
    issue(32'h40, 32'h00001234, 1'b0, 1'b1, MEM_WORD, 1'b0, 1'b0, 5'd9);
    check("stall_read", bus.read_data_out, 32'h44338011);
    check("stall_alu", bus.alu_result_out, 32'h20);
    check("stall_rdest", 32'(bus.reg_dest_address_out), 32'd7);
    bus.stall = 1'b0;
    issue(32'h40, 32'h0, 1'b1, 1'b0, MEM_WORD, 1'b0, 1'b1, 5'd7);
    check("stall_no_store", bus.read_data_out, 32'h55667788);

    // Flush wins over stall: bubble, no store
    bus.stall = 1'b1; bus.flush = 1'b1;
    issue(32'h40, 32'h00009999, 1'b1, 1'b1, MEM_WORD, 1'b0, 1'b1, 5'd4);
    check("flush_regw", 32'(bus.reg_write_out), 32'h0);
    check("flush_read", bus.read_data_out, 32'h0);
    check("flush_alu", bus.alu_result_out, 32'h0);
    check("flush_rdest", 32'(bus.reg_dest_address_out), 32'h0);
    bus.stall = 1'b0; bus.flush = 1'b0;
    issue(32'h40, 32'h0, 1'b1, 1'b0, MEM_WORD, 1'b0, 1'b1, 5'd4);
    check("flush_no_store", bus.read_data_out, 32'h55667788);

    // Same-cycle load+store returns old data; 4 KB aliasing
    issue(32'h80, 32'h0000000A, 1'b0, 1'b1, MEM_WORD, 1'b0, 1'b0, 5'd0);
    issue(32'h80, 32'h0000000B, 1'b1, 1'b1, MEM_WORD, 1'b0, 1'b1, 5'd6);
    check("rbw_old", bus.read_data_out, 32'h0000000A);
    issue(32'h1080, 32'h0, 1'b1, 1'b0, MEM_WORD, 1'b0, 1'b1, 5'd6);
    check("alias_new", bus.read_data_out, 32'h0000000B);
    check("alias_alu", bus.alu_result_out, 32'h1080);

    // Misaligned word store at 0x42
    issue(32'h42, 32'hCAFEF00D, 1'b0, 1'b1, MEM_WORD, 1'b0, 1'b1, 5'd8);
`ifdef MISALIGN_TRAP_EN
    check("mis_flag", 32'(bus.misalign_err), 32'h1);
    check("mis_regw", 32'(bus.reg_write_out), 32'h0);
`else
    check("mis_flag", 32'(bus.misalign_err), 32'h0);
    check("mis_regw", 32'(bus.reg_write_out), 32'h1);
`endif
    issue(32'h40, 32'h0, 1'b1, 1'b0, MEM_WORD, 1'b0, 1'b1, 5'd8);
    check("mis_clear", 32'(bus.misalign_err), 32'h0);
`ifdef MISALIGN_TRAP_EN
    check("mis_store", bus.read_data_out, 32'h55667788);
`else
    check("mis_store", bus.read_data_out, 32'hCAFEF00D);
`endif
    issue(32'h43, 32'h0, 1'b1, 1'b0, MEM_WORD, 1'b0, 1'b1, 5'd8);
`ifdef MISALIGN_TRAP_EN
    check("mis_load", bus.read_data_out, 32'h0);
`else
    check("mis_load", bus.read_data_out, 32'hCAFEF00D);
`endif

    // Asynchronous reset between edges; memory survives
    issue(32'h10, 32'h0, 1'b1, 1'b0, MEM_WORD, 1'b0, 1'b1, 5'd5);
    check("pre_rst_read", bus.read_data_out, 32'hDEADBEEF);
    #2 rst = 1'b1;
    #1;
    check("async_rst_read", bus.read_data_out, 32'h0);
    check("async_rst_regw", 32'(bus.reg_write_out), 32'h0);
    check("async_rst_alu", bus.alu_result_out, 32'h0);
    #1 rst = 1'b0;
    issue(32'h10, 32'h0, 1'b1, 1'b0, MEM_WORD, 1'b0, 1'b1, 5'd5);
    check("post_rst_read", bus.read_data_out, 32'hDEADBEEF);
    check("post_rst_rdest", 32'(bus.reg_dest_address_out), 32'd5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
